// File: rtl/spi_ram_burst_slave.sv
// SPI slave sampled on the system clock, fused with a single-port RAM.
// Commands: 000 write addr, 001 write data, 110 read addr, 111 read data; burst via AUTO_INC.
module spi_ram_burst_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  cmd_err,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] INC = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;

    typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, IGNORE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [1:0]              cmd_sr;
    logic [1:0]              turn;
    logic [MAXW-1:0]         sr;
    logic [DATA_WIDTH-1:0]   tx, rdata, wdata;
    logic [ADDR_WIDTH-1:0]   addr_in, ram_addr;
    logic                    cmd_bad, wr_last, rd_fetch;
    logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

    assign addr_in = {sr[ADDR_WIDTH-2:0], MOSI};
    assign wdata   = {sr[DATA_WIDTH-2:0], MOSI};

    always_comb begin
        state_nxt = state;
        cmd_bad   = 1'b0;
        if (SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: if (cnt == CW'(2)) begin
                    case ({cmd_sr, MOSI})
                        3'b000:  state_nxt = WR_ADDR;
                        3'b001:  state_nxt = WR_DATA;
                        3'b110:  state_nxt = RD_ADDR;
                        3'b111:  state_nxt = RD_DATA;
                        default: begin
                            state_nxt = IGNORE;
                            cmd_bad   = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Read side: turn 0 fetches the first word, turn 1 loads the shifter, turn 2 streams
    // and prefetches the following word while the current MSB goes out.
    always_comb begin
        wr_last  = !rst && !SS_n && state == WR_DATA && cnt == CW'(DATA_WIDTH - 1);
        rd_fetch = !rst && !SS_n && state == RD_DATA &&
                   (turn == 2'd0 || (turn == 2'd2 && cnt == '0));
        ram_addr = rd_addr;
        if (wr_last)
            ram_addr = wr_addr;
        else if (turn != 2'd0)
            ram_addr = rd_addr + INC;
    end

    always_ff @(posedge clk) begin
        if (wr_last)
            mem[ram_addr] <= wdata;
        if (rd_fetch)
            rdata <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MISO    <= 1'b0;
            cmd_err <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
            cnt     <= '0;
            turn    <= '0;
            cmd_sr  <= '0;
            sr      <= '0;
            tx      <= '0;
        end else begin
            cmd_err <= cmd_bad;
            MISO    <= 1'b0;
            if (SS_n) begin
                cnt  <= '0;
                turn <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt  <= '0;
                        turn <= '0;
                    end
                    CMD: begin
                        cmd_sr <= {cmd_sr[0], MOSI};
                        cnt    <= (cnt == CW'(2)) ? '0 : cnt + 1'b1;
                    end
                    WR_ADDR, RD_ADDR: if (cnt < CW'(ADDR_WIDTH)) begin
                        sr  <= {sr[MAXW-2:0], MOSI};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ADDR_WIDTH - 1)) begin
                            if (state == WR_ADDR) wr_addr <= addr_in;
                            else                  rd_addr <= addr_in;
                        end
                    end
                    WR_DATA: begin
                        sr <= {sr[MAXW-2:0], MOSI};
                        if (wr_last) begin
                            cnt     <= '0;
                            wr_addr <= wr_addr + INC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RD_DATA: begin
                        case (turn)
                            2'd0: turn <= 2'd1;
                            2'd1: begin
                                tx   <= rdata;
                                turn <= 2'd2;
                                cnt  <= '0;
                            end
                            default: begin
                                MISO <= tx[DATA_WIDTH-1];
                                if (cnt == CW'(DATA_WIDTH - 1)) begin
                                    tx      <= rdata;
                                    rd_addr <= rd_addr + INC;
                                    cnt     <= '0;
                                end else begin
                                    tx  <= {tx[DATA_WIDTH-2:0], 1'b0};
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Randomized bench for spi_ram_burst_slave against a word-level RAM/address model.
module tb_spi_ram_burst_slave;

    logic       clk = 1'b0;
    logic       rst, SS_n, MOSI, MISO, cmd_err;
    logic [7:0] wr_addr, rd_addr;

    spi_ram_burst_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .cmd_err(cmd_err), .wr_addr(wr_addr), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0, n_fail = 0;
    logic [7:0] m_mem [256];
    logic [7:0] m_wa, m_ra;
    bit         txq[$];
    logic [7:0] rx_words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) txq.push_back(w[i]);
    endtask

    function automatic logic [7:0] txbyte(input int off);
        logic [7:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[6:0], txq[off+i]};
        return w;
    endfunction

    // One SS_n-framed transaction: command, then txq bits, then deselect; model updated after.
    task automatic frame(input logic [2:0] cmd);
        logic       rxq[$];
        logic       quiet;
        logic [7:0] w;
        int         n;
        bit         illegal;
        illegal = !(cmd inside {3'b000, 3'b001, 3'b110, 3'b111});
        SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk);
        for (int i = 2; i >= 0; i--) begin
            MOSI = cmd[i];
            @(negedge clk);
        end
        chk("cmd_err", cmd_err, illegal);
        foreach (txq[i]) begin
            MOSI = txq[i];
            @(negedge clk);
            rxq.push_back(MISO);
            if (i == 0) chk("cmd_err_1cyc", cmd_err, 0);
        end
        SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk);
        chk("miso_after_frame", MISO, 0);
        rx_words.delete();
        quiet = 1'b0;
        case (cmd)
            3'b000: if (txq.size() >= 8) m_wa = txbyte(0);
            3'b110: if (txq.size() >= 8) m_ra = txbyte(0);
            3'b001: begin
                n = txq.size() / 8;
                for (int k = 0; k < n; k++) begin
                    m_mem[m_wa] = txbyte(8 * k);
                    m_wa++;
                end
            end
            3'b111: begin
                for (int i = 0; i < 2 && i < rxq.size(); i++) quiet |= rxq[i];
                chk("rd_turnaround", quiet, 0);
                n = (txq.size() >= 2) ? (txq.size() - 2) / 8 : 0;
                for (int k = 0; k < n; k++) begin
                    w = '0;
                    for (int b = 0; b < 8; b++) w = {w[6:0], rxq[2 + 8*k + b]};
                    rx_words.push_back(w);
                    chk("rd_word", w, m_mem[m_ra]);
                    m_ra++;
                end
            end
            default: ;
        endcase
        if (cmd != 3'b111) begin
            foreach (rxq[i]) quiet |= rxq[i];
            chk("miso_quiet", quiet, 0);
        end
        chk("wr_addr", wr_addr, m_wa);
        chk("rd_addr", rd_addr, m_ra);
        txq.delete();
    endtask

    task automatic rand_bits(input int n);
        for (int i = 0; i < n; i++) txq.push_back(1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [2:0] c;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_miso", MISO, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        m_wa = '0; m_ra = '0;

        // Fill the whole RAM so every later read has a known expectation.
        push_word(8'h00); frame(3'b000);
        for (int i = 0; i < 256; i++) push_word(8'($urandom));
        frame(3'b001);
        chk("fill_wrap", wr_addr, 8'h00);

        // Write then read back.
        push_word(8'h3C); frame(3'b000);
        push_word(8'hA5); frame(3'b001);
        push_word(8'h3C); frame(3'b110);
        rand_bits(10);    frame(3'b111);
        chk("readback_A5", rx_words.size() > 0 ? rx_words[0] : 8'h00, 8'hA5);

        // Burst write/read across the top of the address space.
        push_word(8'hFE); frame(3'b000);
        push_word(8'h11); push_word(8'h22); push_word(8'h33); frame(3'b001);
        chk("burst_wr_addr", wr_addr, 8'h01);
        push_word(8'hFE); frame(3'b110);
        rand_bits(26);    frame(3'b111);
        chk("burst_word2", rx_words.size() > 2 ? rx_words[2] : 8'h00, 8'h33);
        chk("burst_rd_addr", rd_addr, 8'h01);

        // Partial word is discarded.
        push_word(8'h10); frame(3'b000);
        rand_bits(5);     frame(3'b001);
        chk("partial_wr_addr", wr_addr, 8'h10);
        push_word(8'h10); frame(3'b110);
        rand_bits(10);    frame(3'b111);

        // Illegal command with trailing payload.
        push_word(8'($urandom)); frame(3'b010);

        // Reset on the 6th data bit of a write.
        push_word(8'h20); frame(3'b000);
        SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk);
        for (int i = 2; i >= 0; i--) begin
            MOSI = (i == 0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        MOSI = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("midrst_miso", MISO, 0);
        chk("midrst_cmd_err", cmd_err, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        rst = 1'b0; SS_n = 1'b1;
        @(negedge clk);
        m_wa = '0; m_ra = '0;
        push_word(8'h20); frame(3'b110);
        rand_bits(10);    frame(3'b111);

        // Random frames of any command, including illegal ones and ragged lengths.
        for (int t = 0; t < 40; t++) begin
            c = 3'($urandom_range(0, 7));
            if (c == 3'b111) rand_bits(2 + 8 * $urandom_range(0, 4) + $urandom_range(0, 3));
            else             rand_bits($urandom_range(0, 30));
            frame(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
